// File: rtl/lock_entry_ctrl.sv
// ============================================================================
// Module   : lock_entry_ctrl
// Purpose  : Entry stage of the CI-LOCKER lock. It debounces the validar
//            button, shifts in SW digits, checks the code against PASSWORD,
//            and tracks verdict, attempt count and lockout status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_entry_ctrl #(
   parameter int          CLK_HZ          = 50_000_000,
   parameter int          DEBOUNCE_CYCLES = 1_000_000,
   parameter int          DIGITS          = 4,
   parameter logic [15:0] PASSWORD        = 16'h2017,
   parameter int          MAX_FAILS       = 3,
   parameter int          LOCKOUT_SEC     = 10
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        validar,
   input  logic [3:0]  SW,
   output logic [15:0] code_entered,
   output logic [2:0]  digit_count,
   output logic        result_valid,
   output logic        result_ok,
   output logic        result_fail,
   output logic [2:0]  fail_count,
   output logic        locked,
   output logic [3:0]  lock_remain
);

   localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_PS_W = $clog2(CLK_HZ + 1);
   localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_PS_W-1:0] c_PS_LAST   = c_PS_W'(CLK_HZ - 1);
   localparam logic [2:0]        c_DIGITS    = 3'(DIGITS);
   localparam logic [2:0]        c_MAX_FAILS = 3'(MAX_FAILS);
   localparam logic [3:0]        c_LOCK_SEC  = 4'(LOCKOUT_SEC);
   localparam logic [15:0]       c_CODE_MASK = 16'hFFFF >> (16 - 4 * DIGITS);

   typedef enum logic [2:0] {
      S_COLLECT = 3'd0,
      S_CHECK   = 3'd1,
      S_OPEN    = 3'd2,
      S_FAIL    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // Button input path: synchronizer, debouncer, falling-edge press pulse
   // ---------------------------------------------------------------------
   logic              r_sync1;
   logic              r_sync2;
   logic              r_db_level;
   logic [c_DB_W-1:0] r_db_cnt;
   logic              r_press;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_db_level <= 1'b1;
         r_db_cnt   <= '0;
         r_press    <= 1'b0;
      end else begin
         r_sync1 <= validar;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 != r_db_level) begin
            if (r_db_cnt == c_DB_LAST) begin
               r_db_level <= r_sync2;
               r_db_cnt   <= '0;
               r_press    <= ~r_sync2;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Entry / verdict / lockout state machine
   // ---------------------------------------------------------------------
   state_t            r_state, w_state;
   logic [15:0]       r_code,   w_code;
   logic [2:0]        r_digits, w_digits;
   logic              r_valid,  w_valid;
   logic              r_ok,     w_ok;
   logic              r_fail,   w_fail;
   logic [2:0]        r_fails,  w_fails;
   logic              r_locked, w_locked;
   logic [3:0]        r_remain, w_remain;
   logic [c_PS_W-1:0] r_presc,  w_presc;

   logic       w_match;
   logic [2:0] w_fails_inc;

   assign w_match     = ((r_code ^ PASSWORD) & c_CODE_MASK) == 16'h0000;
   assign w_fails_inc = (r_fails < c_MAX_FAILS) ? r_fails + 3'd1 : r_fails;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state  <= S_COLLECT;
         r_code   <= '0;
         r_digits <= '0;
         r_valid  <= 1'b0;
         r_ok     <= 1'b0;
         r_fail   <= 1'b0;
         r_fails  <= '0;
         r_locked <= 1'b0;
         r_remain <= '0;
         r_presc  <= '0;
      end else begin
         r_state  <= w_state;
         r_code   <= w_code;
         r_digits <= w_digits;
         r_valid  <= w_valid;
         r_ok     <= w_ok;
         r_fail   <= w_fail;
         r_fails  <= w_fails;
         r_locked <= w_locked;
         r_remain <= w_remain;
         r_presc  <= w_presc;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_code   = r_code;
      w_digits = r_digits;
      w_valid  = 1'b0;
      w_ok     = r_ok;
      w_fail   = r_fail;
      w_fails  = r_fails;
      w_locked = r_locked;
      w_remain = r_remain;
      w_presc  = r_presc;

      case (r_state)
         S_COLLECT: begin
            if (r_press) begin
               w_code   = {r_code[11:0], SW};
               w_digits = r_digits + 3'd1;
               if (r_digits + 3'd1 == c_DIGITS) begin
                  w_state = S_CHECK;
               end
            end
         end

         S_CHECK: begin
            w_valid = 1'b1;
            if (w_match) begin
               w_ok    = 1'b1;
               w_fail  = 1'b0;
               w_fails = 3'd0;
               w_state = S_OPEN;
            end else begin
               w_ok    = 1'b0;
               w_fail  = 1'b1;
               w_fails = w_fails_inc;
               if (w_fails_inc == c_MAX_FAILS) begin
                  w_locked = 1'b1;
                  w_remain = c_LOCK_SEC;
                  w_presc  = '0;
                  w_state  = S_LOCKOUT;
               end else begin
                  w_state = S_FAIL;
               end
            end
         end

         // The press that acknowledges a verdict only clears; it captures nothing
         S_OPEN, S_FAIL: begin
            if (r_press) begin
               w_ok     = 1'b0;
               w_fail   = 1'b0;
               w_code   = '0;
               w_digits = '0;
               w_state  = S_COLLECT;
            end
         end

         S_LOCKOUT: begin
            if (r_presc == c_PS_LAST) begin
               w_presc = '0;
               if (r_remain <= 4'd1) begin
                  w_locked = 1'b0;
                  w_remain = '0;
                  w_fail   = 1'b0;
                  w_fails  = '0;
                  w_code   = '0;
                  w_digits = '0;
                  w_state  = S_COLLECT;
               end else begin
                  w_remain = r_remain - 4'd1;
               end
            end else begin
               w_presc = r_presc + 1'b1;
            end
         end

         default: begin
            w_state = S_COLLECT;
         end
      endcase
   end

   assign code_entered = r_code;
   assign digit_count  = r_digits;
   assign result_valid = r_valid;
   assign result_ok    = r_ok;
   assign result_fail  = r_fail;
   assign fail_count   = r_fails;
   assign locked       = r_locked;
   assign lock_remain  = r_remain;

endmodule

`default_nettype wire

// File: tb/tb_lock_entry_ctrl.sv
// ============================================================================
// Module   : tb_lock_entry_ctrl
// Purpose  : Scoreboard bench for lock_entry_ctrl: directed entries push their
//            expected verdicts, a monitor compares them on result_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_entry_ctrl;

   localparam logic [15:0] c_PW = 16'h2017;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        validar  = 1'b1;
   logic [3:0]  SW       = 4'h0;
   logic [15:0] code_entered;
   logic [2:0]  digit_count;
   logic        result_valid;
   logic        result_ok;
   logic        result_fail;
   logic [2:0]  fail_count;
   logic        locked;
   logic [3:0]  lock_remain;

   lock_entry_ctrl #(
      .CLK_HZ          (10),
      .DEBOUNCE_CYCLES (4),
      .DIGITS          (4),
      .PASSWORD        (c_PW),
      .MAX_FAILS       (3),
      .LOCKOUT_SEC     (3)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .validar      (validar),
      .SW           (SW),
      .code_entered (code_entered),
      .digit_count  (digit_count),
      .result_valid (result_valid),
      .result_ok    (result_ok),
      .result_fail  (result_fail),
      .fail_count   (fail_count),
      .locked       (locked),
      .lock_remain  (lock_remain)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic        ok;
      logic        fail;
      logic [2:0]  fc;
      logic        lk;
      logic [3:0]  rem;
      logic [15:0] code;
   } verdict_t;

   verdict_t sb_q[$];
   int       vectors     = 0;
   int       miscompares = 0;
   int       exp_fails   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every verdict pulse must match the oldest queued expectation
   always @(negedge CLOCK_50) begin
      if (!reset && result_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_verdict", 32'd1, 32'd0);
         end else begin
            verdict_t e;
            e = sb_q.pop_front();
            check("v_ok",     {31'd0, result_ok},   {31'd0, e.ok});
            check("v_fail",   {31'd0, result_fail}, {31'd0, e.fail});
            check("v_fcount", {29'd0, fail_count},  {29'd0, e.fc});
            check("v_locked", {31'd0, locked},      {31'd0, e.lk});
            check("v_remain", {28'd0, lock_remain}, {28'd0, e.rem});
            check("v_code",   {16'd0, code_entered}, {16'd0, e.code});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic do_press(input logic [3:0] d);
      SW = d;
      validar = 1'b0;
      tick(8);
      validar = 1'b1;
      tick(10);
   endtask

   // Reference model of the verdict for a complete entry
   task automatic expect_verdict(input logic [15:0] c);
      verdict_t e;
      e.code = c;
      if (c == c_PW) begin
         exp_fails = 0;
         e.ok = 1'b1; e.fail = 1'b0; e.lk = 1'b0; e.rem = 4'd0;
      end else begin
         if (exp_fails < 3) exp_fails++;
         e.ok = 1'b0; e.fail = 1'b1;
         e.lk  = (exp_fails == 3);
         e.rem = (exp_fails == 3) ? 4'd3 : 4'd0;
      end
      e.fc = 3'(exp_fails);
      sb_q.push_back(e);
   endtask

   task automatic enter_code(input logic [15:0] c);
      expect_verdict(c);
      for (int i = 0; i < 4; i++) do_press(c[15-4*i -: 4]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_code"},   {16'd0, code_entered}, 32'd0);
      check({tag, "_digits"}, {29'd0, digit_count},  32'd0);
      check({tag, "_flags"},  {28'd0, result_valid, result_ok, result_fail, locked}, 32'd0);
      check({tag, "_fc"},     {29'd0, fail_count},   32'd0);
      check({tag, "_remain"}, {28'd0, lock_remain},  32'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check_all_zero("rst_async");
      exp_fails = 0;
      tick(2);
      reset = 1'b0;
      tick(2);
   endtask

   initial begin
      // Reset state
      tick(3);
      check_all_zero("reset");
      reset = 1'b0;
      tick(3);

      // Bounce: short lows are rejected, a long low is one press
      SW = 4'h2;
      validar = 1'b0; tick(3);
      validar = 1'b1; tick(1);
      validar = 1'b0; tick(3);
      validar = 1'b1; tick(10);
      check("bounce_nopress", {29'd0, digit_count}, 32'd0);
      validar = 1'b0; tick(6);
      validar = 1'b1; tick(10);
      check("bounce_onepress", {29'd0, digit_count}, 32'd1);
      check("bounce_code", {16'd0, code_entered}, 32'h2);

      // Correct entry completing the bounce digit
      expect_verdict(16'h2017);
      do_press(4'h0); do_press(4'h1); do_press(4'h7);
      check("ok_code", {16'd0, code_entered}, 32'h2017);
      check("ok_level", {31'd0, result_ok}, 32'd1);
      do_press(4'h5);
      check_all_zero("ok_clear");

      // Wrong entry, then acknowledge without capturing
      enter_code(16'h2016);
      check("fail_level", {31'd0, result_fail}, 32'd1);
      check("fail_unlocked", {31'd0, locked}, 32'd0);
      do_press(4'h3);
      check("fail_clear", {31'd0, result_fail}, 32'd0);
      check("fail_clear_digits", {29'd0, digit_count}, 32'd0);
      check("fail_keep_fc", {29'd0, fail_count}, 32'd1);

      // Recovery: correct code after a wrong one clears the count
      enter_code(c_PW);
      check("recover_fc", {29'd0, fail_count}, 32'd0);
      do_press(4'h0);

      // Lockout after three consecutive wrong codes
      enter_code(16'h1111); do_press(4'h0);
      enter_code(16'h2222); do_press(4'h0);
      expect_verdict(16'h2016);
      do_press(4'h2); do_press(4'h0); do_press(4'h1);
      SW = 4'h6;
      validar = 1'b0;
      begin
         int guard;
         guard = 0;
         while (!result_valid && guard < 40) begin
            tick(1);
            guard++;
         end
         check("lockout_verdict_seen", {31'd0, result_valid}, 32'd1);
      end
      for (int k = 1; k <= 31; k++) begin
         tick(1);
         if (k == 5)  validar = 1'b1;
         if (k == 13) begin SW = 4'h9; validar = 1'b0; end
         if (k == 23) validar = 1'b1;
         if (k == 9)  check("lk_rem_k9",  {28'd0, lock_remain}, 32'd3);
         if (k == 10) check("lk_rem_k10", {28'd0, lock_remain}, 32'd2);
         if (k == 20) check("lk_rem_k20", {28'd0, lock_remain}, 32'd1);
         if (k == 25) begin
            check("lk_ignore_digits", {29'd0, digit_count}, 32'd4);
            check("lk_ignore_code", {16'd0, code_entered}, 32'h2016);
         end
         if (k == 29) check("lk_still_locked", {31'd0, locked}, 32'd1);
         if (k == 30) check_all_zero("unlock");
      end
      exp_fails = 0;
      tick(10);

      // Reset mid-entry, then a clean entry
      do_press(4'h2); do_press(4'h0);
      check("mid_digits", {29'd0, digit_count}, 32'd2);
      pulse_reset();
      enter_code(c_PW);
      do_press(4'h0);

      // Reset mid-lockout, then a clean entry
      enter_code(16'h1234); do_press(4'h0);
      enter_code(16'h1234); do_press(4'h0);
      enter_code(16'h1234);
      check("pre_reset_locked", {31'd0, locked}, 32'd1);
      pulse_reset();
      enter_code(c_PW);
      check("post_reset_ok", {31'd0, result_ok}, 32'd1);

      tick(5);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
